// File: rtl/fsm_collect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_collect_pkg
// Description : Shared types and constants for the nibble-serial result
//               collector: assembly FSM state encoding, default frame length
//               and counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_collect_pkg;

  // Assembly FSM states
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } collect_state_t;

  // Default nibbles per frame (64-bit word, 4-bit nibbles)
  localparam int NIBBLES = 16;

  // Nibble counter width for the default frame length
  localparam int CNT_W = $clog2(NIBBLES);

  // Counter width for an arbitrary frame length, never narrower than 1 bit
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_word_fifo
// Description : Small synchronous FIFO for completed result words. Pointers
//               carry one extra wrap bit so full and empty are distinguished.
//               A push while full is accepted only if a pop happens in the
//               same cycle. Head data reads as zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module result_word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_do_pop  = pop && !w_empty;
  assign w_do_push = push && (!w_full || w_do_pop);

  // Read and write pointers, each with a wrap bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset needed
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign head_data = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: rtl/fsm_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : fsm_result_collector
// Description : Reassembles nibble-serial FSM results into N-bit words,
//               buffers them in a small FIFO with a valid/ready output,
//               flags truncated frames and dropped words, counts frames.
//               Optional macro FSM_COLLECT_XSUM_EN adds a per-word XOR
//               checksum of the frame's nibbles on res_xsum.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_result_collector
  import fsm_collect_pkg::*;
#(
  parameter int N       = 64,
  parameter int N_width = 4,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nib_valid,
  input  logic [N_width-1:0] nib_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N-1:0]       res_data,
  output logic [N_width-1:0] res_xsum,
  output logic               frame_err,
  output logic               overflow,
  input  logic               clr_flags,
  output logic [7:0]         frames_done
);

  localparam int c_nibbles = N / N_width;
  localparam int c_cnt_w   = (c_nibbles == NIBBLES) ? CNT_W : cnt_width(c_nibbles);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nibbles - 1);
`ifdef FSM_COLLECT_XSUM_EN
  localparam int c_fifo_w = N + N_width;
`else
  localparam int c_fifo_w = N;
`endif

  collect_state_t      r_state;
  collect_state_t      w_state_next;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_next;
  logic [N-1:0]        r_word;
  logic [N-1:0]        w_word;
  logic                w_push;
  logic                w_abort;
  logic                w_pop;
  logic                w_push_ok;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [c_fifo_w-1:0] w_fifo_in;
  logic [c_fifo_w-1:0] w_fifo_head;
  logic                r_frame_err;
  logic                r_overflow;
  logic [7:0]          r_frames_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state, next count, push/abort strobes
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_push       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (nib_valid) begin
          w_state_next = ASSEMBLE;
          w_cnt_next   = c_cnt_w'(1);
        end
      end
      ASSEMBLE: begin
        if (nib_valid) begin
          if (r_cnt == c_last) begin
            w_push       = 1'b1;
            w_cnt_next   = '0;
            w_state_next = IDLE;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end else begin
          w_abort      = 1'b1;
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Current word with this cycle's nibble merged in; count is 0 in IDLE
  always_comb begin
    w_word = r_word;
    w_word[int'(r_cnt)*N_width +: N_width] = nib_data;
  end

  // Nibble counter and partial word; an abort discards the partial word
  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (nib_valid) r_word <= w_word;
    end
  end

`ifdef FSM_COLLECT_XSUM_EN
  logic [N_width-1:0] r_xsum;
  logic [N_width-1:0] w_xsum;

  // Running XOR restarts with the first nibble of each frame
  always_comb begin
    w_xsum = ((r_state == IDLE) ? '0 : r_xsum) ^ nib_data;
  end

  // Running XOR register, cleared on abort
  always_ff @(posedge clk) begin
    if (rst || w_abort) r_xsum <= '0;
    else if (nib_valid) r_xsum <= w_xsum;
  end

  assign w_fifo_in             = {w_xsum, w_word};
  assign {res_xsum, res_data}  = w_fifo_head;
`else
  assign w_fifo_in = w_word;
  assign res_data  = w_fifo_head;
  assign res_xsum  = '0;
`endif

  assign res_valid = !w_fifo_empty;
  assign w_pop     = res_valid && res_ready;
  // A full FIFO still takes the word when the head leaves in the same cycle
  assign w_push_ok = w_push && (!w_fifo_full || w_pop);

  result_word_fifo #(
    .WIDTH (c_fifo_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_fifo_in),
    .pop       (w_pop),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .head_data (w_fifo_head)
  );

  // Sticky flags (set beats clear) and wrapping frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err   <= 1'b0;
      r_overflow    <= 1'b0;
      r_frames_done <= '0;
    end else begin
      if (w_abort)        r_frame_err <= 1'b1;
      else if (clr_flags) r_frame_err <= 1'b0;
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
      else if (clr_flags)       r_overflow <= 1'b0;
      if (w_push_ok) r_frames_done <= r_frames_done + 8'd1;
    end
  end

  assign frame_err   = r_frame_err;
  assign overflow    = r_overflow;
  assign frames_done = r_frames_done;

endmodule
`default_nettype wire

// File: tb/tb_fsm_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_result_collector
// Description : Directed self-checking bench for fsm_result_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        nib_valid;
  logic [3:0]  nib_data;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [3:0]  res_xsum;
  logic        frame_err;
  logic        overflow;
  logic        clr_flags;
  logic [7:0]  frames_done;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef FSM_COLLECT_XSUM_EN
  bit xsum_en = 1'b1;
`else
  bit xsum_en = 1'b0;
`endif

  always #5 clk = ~clk;

  fsm_result_collector #(.N(64), .N_width(4), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .nib_valid   (nib_valid),
    .nib_data    (nib_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_xsum    (res_xsum),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .clr_flags   (clr_flags),
    .frames_done (frames_done)
  );

  // Inputs are applied at a falling edge; after the next falling edge the
  // outputs reflect the rising edge that sampled them.
  task automatic tick(input logic v, input logic [3:0] d);
    nib_valid = v;
    nib_data  = d;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] w);
    for (int k = 0; k < 16; k++) tick(1'b1, w[k*4 +: 4]);
  endtask

  task automatic do_reset();
    rst = 1'b1; clr_flags = 1'b0;
    tick(1'b0, 4'h0);
    tick(1'b0, 4'h0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_flags = 1'b0; res_ready = 1'b0;
    tick(1'b1, 4'hF);
    tick(1'b1, 4'hF);
    n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", res_valid); else n_pass++;
    n_checks++; if (res_data !== 64'h0) $display("FAIL reset_data: got %h expected 0", res_data); else n_pass++;
    n_checks++; if (res_xsum !== 4'h0) $display("FAIL reset_xsum: got %h expected 0", res_xsum); else n_pass++;
    n_checks++; if ({frame_err, overflow} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {frame_err, overflow}); else n_pass++;
    n_checks++; if (frames_done !== 8'd0) $display("FAIL reset_frames: got %0d expected 0", frames_done); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    do_reset();
    res_ready = 1'b1;
    send_frame(64'h0FEDCBA987654321);
    n_checks++; if (res_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", res_valid); else n_pass++;
    n_checks++; if (res_data !== 64'h0FEDCBA987654321) $display("FAIL single_data: got %h expected 0fedcba987654321", res_data); else n_pass++;
    n_checks++; if (frames_done !== 8'd1) $display("FAIL single_frames: got %0d expected 1", frames_done); else n_pass++;
    n_checks++; if (res_xsum !== 4'h0) $display("FAIL single_xsum: got %h expected 0", res_xsum); else n_pass++;
    tick(1'b0, 4'h0);
    n_checks++; if (res_valid !== 1'b0) $display("FAIL single_popped: got %b expected 0", res_valid); else n_pass++;
    n_checks++; if (res_data !== 64'h0) $display("FAIL single_empty_data: got %h expected 0", res_data); else n_pass++;
  endtask

  task automatic test_truncated();
    do_reset();
    res_ready = 1'b1;
    for (int k = 1; k <= 5; k++) tick(1'b1, 4'(k));
    tick(1'b0, 4'h0);
    n_checks++; if (frame_err !== 1'b1) $display("FAIL trunc_err: got %b expected 1", frame_err); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL trunc_valid: got %b expected 0", res_valid); else n_pass++;
    n_checks++; if (frames_done !== 8'd0) $display("FAIL trunc_frames: got %0d expected 0", frames_done); else n_pass++;
    send_frame(64'hAAAAAAAAAAAAAAAA);
    n_checks++; if (res_data !== 64'hAAAAAAAAAAAAAAAA) $display("FAIL trunc_next_data: got %h expected aaaaaaaaaaaaaaaa", res_data); else n_pass++;
    n_checks++; if (frames_done !== 8'd1) $display("FAIL trunc_next_frames: got %0d expected 1", frames_done); else n_pass++;
    n_checks++; if (frame_err !== 1'b1) $display("FAIL trunc_sticky: got %b expected 1", frame_err); else n_pass++;
  endtask

  task automatic test_back_to_back_overflow();
    do_reset();
    res_ready = 1'b0;
    send_frame(64'h1111111111111111);
    send_frame(64'h2222222222222222);
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b expected 0", overflow); else n_pass++;
    send_frame(64'h3333333333333333);
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow); else n_pass++;
    n_checks++; if (frames_done !== 8'd2) $display("FAIL ovf_frames: got %0d expected 2", frames_done); else n_pass++;
    tick(1'b0, 4'h0);
    n_checks++; if (res_data !== 64'h1111111111111111) $display("FAIL ovf_head_stable: got %h expected 1111111111111111", res_data); else n_pass++;
    res_ready = 1'b1;
    tick(1'b0, 4'h0);
    n_checks++; if (res_data !== 64'h2222222222222222 || res_valid !== 1'b1) $display("FAIL ovf_second: got %h/%b expected 2222222222222222/1", res_data, res_valid); else n_pass++;
    tick(1'b0, 4'h0);
    n_checks++; if (res_valid !== 1'b0) $display("FAIL ovf_drained: got %b expected 0", res_valid); else n_pass++;
    res_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    res_ready = 1'b0;
    send_frame(64'h1111111111111111);
    send_frame(64'h2222222222222222);
    for (int k = 0; k < 15; k++) tick(1'b1, 4'h5);
    res_ready = 1'b1;
    tick(1'b1, 4'h5);
    res_ready = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL pp_overflow: got %b expected 0", overflow); else n_pass++;
    n_checks++; if (frames_done !== 8'd3) $display("FAIL pp_frames: got %0d expected 3", frames_done); else n_pass++;
    n_checks++; if (res_data !== 64'h2222222222222222) $display("FAIL pp_head: got %h expected 2222222222222222", res_data); else n_pass++;
    res_ready = 1'b1;
    tick(1'b0, 4'h0);
    n_checks++; if (res_data !== 64'h5555555555555555) $display("FAIL pp_second: got %h expected 5555555555555555", res_data); else n_pass++;
    tick(1'b0, 4'h0);
    n_checks++; if (res_valid !== 1'b0) $display("FAIL pp_drained: got %b expected 0", res_valid); else n_pass++;
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    res_ready = 1'b0;
    send_frame(64'h1111111111111111);
    for (int k = 0; k < 8; k++) tick(1'b1, 4'h7);
    rst = 1'b1;
    tick(1'b1, 4'h7);
    n_checks++; if (res_valid !== 1'b0 || res_data !== 64'h0) $display("FAIL mid_rst_fifo: got %b/%h expected 0/0", res_valid, res_data); else n_pass++;
    n_checks++; if (frames_done !== 8'd0 || res_xsum !== 4'h0) $display("FAIL mid_rst_cnt: got %0d/%h expected 0/0", frames_done, res_xsum); else n_pass++;
    rst = 1'b0;
    send_frame(64'hFEDCBA9876543210);
    n_checks++; if (res_data !== 64'hFEDCBA9876543210) $display("FAIL mid_rst_data: got %h expected fedcba9876543210", res_data); else n_pass++;
    n_checks++; if (frame_err !== 1'b0 || frames_done !== 8'd1) $display("FAIL mid_rst_status: got %b/%0d expected 0/1", frame_err, frames_done); else n_pass++;
  endtask

  task automatic test_xsum();
    logic [3:0] exp_x;
    do_reset();
    res_ready = 1'b1;
    tick(1'b1, 4'hF);
    tick(1'b0, 4'h0);
    send_frame(64'h000000000000C000);
    exp_x = xsum_en ? 4'hC : 4'h0;
    n_checks++; if (res_data !== 64'h000000000000C000) $display("FAIL xsum_data: got %h expected 000000000000c000", res_data); else n_pass++;
    n_checks++; if (res_xsum !== exp_x) $display("FAIL xsum_value: got %h expected %h", res_xsum, exp_x); else n_pass++;
    send_frame(64'h0000000000000E31);
    exp_x = xsum_en ? 4'hC : 4'h0;
    n_checks++; if (res_data !== 64'h0000000000000E31) $display("FAIL xsum_b2b_data: got %h expected 0000000000000e31", res_data); else n_pass++;
    n_checks++; if (res_xsum !== exp_x) $display("FAIL xsum_b2b_value: got %h expected %h", res_xsum, exp_x); else n_pass++;
    tick(1'b0, 4'h0);
    res_ready = 1'b0;
  endtask

  task automatic test_flag_clear();
    do_reset();
    res_ready = 1'b0;
    send_frame(64'h1111111111111111);
    send_frame(64'h2222222222222222);
    tick(1'b1, 4'h9);
    tick(1'b1, 4'h9);
    tick(1'b0, 4'h0);
    n_checks++; if (frame_err !== 1'b1) $display("FAIL clr_err_set: got %b expected 1", frame_err); else n_pass++;
    tick(1'b1, 4'h9);
    clr_flags = 1'b1;
    tick(1'b0, 4'h0);
    clr_flags = 1'b0;
    n_checks++; if (frame_err !== 1'b1) $display("FAIL clr_err_set_wins: got %b expected 1", frame_err); else n_pass++;
    for (int k = 0; k < 15; k++) tick(1'b1, 4'h4);
    clr_flags = 1'b1;
    tick(1'b1, 4'h4);
    clr_flags = 1'b0;
    n_checks++; if (overflow !== 1'b1 || frame_err !== 1'b0) $display("FAIL clr_ovf_set_wins: got ovf=%b err=%b expected 1/0", overflow, frame_err); else n_pass++;
    tick(1'b1, 4'h9);
    tick(1'b0, 4'h0);
    clr_flags = 1'b1;
    tick(1'b0, 4'h0);
    clr_flags = 1'b0;
    n_checks++; if (frame_err !== 1'b0 || overflow !== 1'b0) $display("FAIL clr_quiet: got err=%b ovf=%b expected 0/0", frame_err, overflow); else n_pass++;
    n_checks++; if (frames_done !== 8'd2) $display("FAIL clr_frames: got %0d expected 2", frames_done); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; nib_valid = 1'b0; nib_data = 4'h0; res_ready = 1'b0; clr_flags = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_truncated();
    test_back_to_back_overflow();
    test_full_push_pop();
    test_reset_mid_frame();
    test_xsum();
    test_flag_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
